// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control unit: sequences FETCH/DECODE/EXEC/MEM/WB around an
// instruction register and drives datapath controls purely from registered state.
module multicycle_ctrl #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ALU_CTRL_WIDTH    = 4,
  parameter int MEM_TIMEOUT       = 15,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [INSTRUCTION_WIDTH-1:0] inst,
  input  logic                         imem_ack,
  input  logic                         dmem_ack,
  output logic                         imem_req,
  output logic [ALU_CTRL_WIDTH-1:0]    alu_ctrl,
  output logic                         alu_op2_sel,
  output logic                         reg_file_wr_en,
  output logic                         reg_file_wr_back_sel,
  output logic                         data_mem_rd_en,
  output logic                         data_mem_wr_en,
  output logic                         pc_wr_en,
  output logic                         illegal_inst,
  output logic                         mem_fault,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         retired_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t                       state_q;
  logic [INSTRUCTION_WIDTH-1:0] ir_q;
  logic [TW-1:0]                tmo_q;
  logic [CNT_WIDTH-1:0]         ret_q;
  logic                         done_q;   // store completion / timeout PC strobe
  logic                         fault_q;

  logic [6:0] opc;
  logic       is_r, is_imm, is_ld, is_st, legal, in_alu;
  logic [3:0] alu4;
  state_t     nxt_instr;
  logic       unused_ir;

  assign opc    = ir_q[6:0];
  assign is_r   = (opc == 7'b0110011);
  assign is_imm = (opc == 7'b0010011);
  assign is_ld  = (opc == 7'b0000011);
  assign is_st  = (opc == 7'b0100011);
  assign legal  = is_r | is_imm | is_ld | is_st;
  assign unused_ir = ^ir_q;

  // funct7 bit 5 (IR[30]) is what separates SUB from ADD and SRA/SRAI from SRL/SRLI
  always_comb begin
    alu4 = 4'b0000;
    if (is_r)
      alu4 = {ir_q[30], ir_q[14:12]};
    else if (is_imm)
      alu4 = (ir_q[14:12] == 3'b101) ? {ir_q[30], 3'b101} : {1'b0, ir_q[14:12]};
  end

  assign nxt_instr = run ? S_FETCH : S_IDLE;
  assign in_alu    = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  assign imem_req             = (state_q == S_FETCH);
  assign alu_ctrl             = in_alu ? ALU_CTRL_WIDTH'(alu4) : '0;
  assign alu_op2_sel          = in_alu & ~is_r;
  assign reg_file_wr_back_sel = in_alu & (is_r | is_imm);
  assign reg_file_wr_en       = (state_q == S_WB);
  assign data_mem_rd_en       = (state_q == S_MEM) & is_ld;
  assign data_mem_wr_en       = (state_q == S_MEM) & is_st;
  assign illegal_inst         = (state_q == S_DECODE) & ~legal;
  assign pc_wr_en             = (state_q == S_WB) | illegal_inst | done_q;
  assign mem_fault            = fault_q;
  assign busy                 = (state_q != S_IDLE);
  assign retired_cnt          = ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      tmo_q   <= '0;
      ret_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE:   if (run) state_q <= S_FETCH;
        S_FETCH:  if (imem_ack) begin
                    ir_q    <= inst;
                    state_q <= S_DECODE;
                  end
        S_DECODE: state_q <= legal ? S_EXEC : nxt_instr;
        S_EXEC: begin
          tmo_q   <= '0;
          state_q <= (is_ld | is_st) ? S_MEM : S_WB;
        end
        S_MEM: begin
          // a late ack in the final allowed cycle still completes the access
          if (dmem_ack) begin
            if (is_ld) begin
              state_q <= S_WB;
            end else begin
              done_q  <= 1'b1;
              ret_q   <= ret_q + 1'b1;
              state_q <= nxt_instr;
            end
          end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            state_q <= nxt_instr;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WB: begin
          ret_q   <= ret_q + 1'b1;
          state_q <= nxt_instr;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected
// completion records; a monitor checks each pc_wr_en event against them.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] inst = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, alu_op2_sel, reg_file_wr_en, reg_file_wr_back_sel;
  logic        data_mem_rd_en, data_mem_wr_en, pc_wr_en, illegal_inst, mem_fault, busy;
  logic [3:0]  alu_ctrl;
  logic [3:0]  retired_cnt;

  multicycle_ctrl #(.INSTRUCTION_WIDTH(32), .ALU_CTRL_WIDTH(4), .MEM_TIMEOUT(15), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .alu_ctrl(alu_ctrl), .alu_op2_sel(alu_op2_sel),
    .reg_file_wr_en(reg_file_wr_en), .reg_file_wr_back_sel(reg_file_wr_back_sel),
    .data_mem_rd_en(data_mem_rd_en), .data_mem_wr_en(data_mem_wr_en), .pc_wr_en(pc_wr_en),
    .illegal_inst(illegal_inst), .mem_fault(mem_fault), .busy(busy), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] alu;
    logic       op2;
    logic       wb;
    logic       wr;
    logic       ill;
    logic       flt;
    int         rd;
    int         wrc;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   errors = 0;
  int   exp_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] alu, input logic op2, input logic wb,
                              input logic wr, input logic ill, input logic flt,
                              input int rd, input int wrc, input int lat);
    exp_t e;
    e.alu = alu; e.op2 = op2; e.wb = wb; e.wr = wr; e.ill = ill; e.flt = flt;
    e.rd = rd; e.wrc = wrc; e.lat = lat;
    return e;
  endfunction

  // Monitor: tracks latency and memory-enable cycles since the last fetch start
  initial begin
    int lat = 0, rd = 0, wrc = 0;
    int lat_now, rd_now, wr_now;
    logic req_prev = 1'b0;
    logic [3:0] alu_seen = '0;
    logic op2_seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0; rd = 0; wrc = 0; req_prev = 1'b0;
      end else begin
        lat_now = lat + 1;
        rd_now  = rd + int'(data_mem_rd_en);
        wr_now  = wrc + int'(data_mem_wr_en);
        if (data_mem_rd_en | data_mem_wr_en | reg_file_wr_en) begin
          alu_seen = alu_ctrl;
          op2_seen = alu_op2_sel;
        end
        if (pc_wr_en) begin
          if (q.size() == 0) begin
            chk("unexpected_pc_wr_en", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("illegal_inst", 32'(illegal_inst), 32'(e.ill));
            chk("mem_fault", 32'(mem_fault), 32'(e.flt));
            chk("reg_file_wr_en", 32'(reg_file_wr_en), 32'(e.wr));
            if (e.wr) chk("wr_back_sel", 32'(reg_file_wr_back_sel), 32'(e.wb));
            if (!e.ill) begin
              chk("alu_ctrl", 32'(alu_seen), 32'(e.alu));
              chk("alu_op2_sel", 32'(op2_seen), 32'(e.op2));
            end
            chk("rd_en_cycles", 32'(rd_now), 32'(e.rd));
            chk("wr_en_cycles", 32'(wr_now), 32'(e.wrc));
            chk("latency", 32'(lat_now), 32'(e.lat));
          end
        end else if (illegal_inst | mem_fault | reg_file_wr_en) begin
          chk("pulse_without_pc_wr_en", 32'({illegal_inst, mem_fault, reg_file_wr_en}), 32'd0);
        end
        if (imem_req && !req_prev) begin
          lat = 1; rd = 0; wrc = 0;
        end else begin
          lat = lat_now; rd = rd_now; wrc = wr_now;
        end
        req_prev = imem_req;
      end
    end
  end

  // Issue one instruction; dly = MEM wait cycles before ack (-1 = never ack)
  task automatic issue(input logic [31:0] w, input int dly, input exp_t e, input bit retire);
    int k = 0;
    bit seen = 0, done = 0;
    q.push_back(e);
    @(negedge clk);
    inst = w; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (imem_req) seen = 1;
    end
    run = 1'b0;
    if (!seen) chk("fetch_timeout", 32'd0, 32'd1);
    for (int n = 0; n < 100 && !done; n++) begin
      if (data_mem_rd_en | data_mem_wr_en) begin
        k++;
        dmem_ack = (k == dly + 1);
      end else begin
        dmem_ack = 1'b0;
      end
      if (!busy) done = 1;
      else @(negedge clk);
    end
    dmem_ack = 1'b0;
    if (!done) chk("complete_timeout", 32'd0, 32'd1);
    if (retire) exp_ret++;
    chk("retired_cnt", 32'(retired_cnt), 32'(exp_ret % 16));
  endtask

  initial begin
    bit seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({imem_req, alu_ctrl, alu_op2_sel, reg_file_wr_en, reg_file_wr_back_sel,
        data_mem_rd_en, data_mem_wr_en, pc_wr_en, illegal_inst, mem_fault, busy, retired_cnt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_run_busy", 32'(busy), 32'd0);

    //     inst          dly  alu     op2 wb  wr  ill flt rd wr lat         retire
    issue(32'h002081B3,  0, mk(4'b0000, 0, 1, 1, 0, 0, 0, 0, 4),  1); // add
    issue(32'h40208233,  0, mk(4'b1000, 0, 1, 1, 0, 0, 0, 0, 4),  1); // sub
    issue(32'h4020D093,  0, mk(4'b1101, 1, 1, 1, 0, 0, 0, 0, 4),  1); // srai
    issue(32'h40008093,  0, mk(4'b0000, 1, 1, 1, 0, 0, 0, 0, 4),  1); // addi, bit30 ignored
    issue(32'h0000A183,  3, mk(4'b0000, 1, 0, 1, 0, 0, 4, 0, 8),  1); // lw, 3 wait
    issue(32'h0000A183,  0, mk(4'b0000, 1, 0, 1, 0, 0, 1, 0, 5),  1); // lw, zero wait
    issue(32'h0020A023, -1, mk(4'b0000, 1, 0, 0, 0, 1, 0, 15, 19), 0); // sw, timeout
    issue(32'h0020A023, 14, mk(4'b0000, 1, 0, 0, 0, 0, 0, 15, 19), 1); // sw, ack on cycle 15
    issue(32'h0020A023,  0, mk(4'b0000, 1, 0, 0, 0, 0, 0, 1, 5),  1); // sw, zero wait
    issue(32'h00000000,  0, mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 2),  0); // illegal
    issue(32'h0000007F,  0, mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 2),  0); // illegal opcode

    // Reset while a load is stalled in MEM
    @(negedge clk);
    inst = 32'h0000A183; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (imem_req) run = 1'b0;
      if (data_mem_rd_en) seen = 1;
    end
    if (!seen) chk("reach_mem_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({imem_req, alu_ctrl, alu_op2_sel, reg_file_wr_en, reg_file_wr_back_sel,
        data_mem_rd_en, data_mem_wr_en, pc_wr_en, illegal_inst, mem_fault, busy}), 32'd0);
    chk("async_reset_retired", 32'(retired_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    chk("post_reset_idle", 32'({busy, pc_wr_en, mem_fault}), 32'd0);

    // 17 retires on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++)
      issue(32'h002081B3, 0, mk(4'b0000, 0, 1, 1, 0, 0, 0, 0, 4), 1);
    chk("retired_wrap", 32'(retired_cnt), 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
